// File: rtl/tinyyolo_pattern_pkg.sv
// Shared types and helpers for the TinyYOLO AXI4-Stream pattern source.
// Used by the generator top and its per-lane value register.
package tinyyolo_pattern_pkg;

  typedef enum logic [1:0] {
    PM_INCR  = 2'd0,
    PM_CONST = 2'd1,
    PM_LFSR  = 2'd2
  } pattern_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RUN,
    ST_DONE
  } gen_state_t;

  // Galois step; callers keep value and poly within their lane width
  function automatic logic [63:0] lfsr_step(
    input logic [63:0] value,
    input logic [63:0] poly
  );
    logic [63:0] s;
    s = value >> 1;
    if (value[0]) s = s ^ poly;
    return s;
  endfunction

  function automatic logic [63:0] final_tkeep(
    input logic [63:0] len,
    input int          bytes
  );
    logic [63:0] rem;
    logic [63:0] full;
    full = (bytes >= 64) ? '1 : (64'd1 << bytes) - 64'd1;
    rem  = len % 64'(bytes);
    if (rem == '0) return full;
    return (64'd1 << rem) - 64'd1;
  endfunction

endpackage

// File: rtl/tinyyolo_pattern_lane.sv
// One output lane of the pattern source: loads its start value at launch
// and advances once per accepted beat according to the latched mode.
module tinyyolo_pattern_lane
  import tinyyolo_pattern_pkg::*;
#(
  parameter int          N    = 32,
  parameter logic [N-1:0] POLY = '1
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         load,
  input  logic [N-1:0] init,
  input  logic         step,
  input  logic [1:0]   mode,
  input  logic [N-1:0] incr,
  output logic [N-1:0] value
);

  always_ff @(posedge aclk) begin
    if (areset) begin
      value <= '0;
    end else if (load) begin
      value <= init;
    end else if (step) begin
      case (mode)
        PM_CONST: value <= value;
        PM_LFSR:  value <= N'(lfsr_step(64'(value), 64'(POLY)));
        default:  value <= value + incr;
      endcase
    end
  end

endmodule

// File: rtl/tinyyolo_stream_pattern_gen.sv
// AXI4-Stream test-pattern source: burst of INCR/CONST/LFSR lane data
// with runtime length, seed, stride and mode latched on the start edge.
module tinyyolo_stream_pattern_gen
  import tinyyolo_pattern_pkg::*;
#(
  parameter int          C_M_AXIS_TDATA_WIDTH = 128,
  parameter int          C_NUMBER_BIT_WIDTH   = 32,
  parameter int          C_LENGTH_WIDTH       = 32,
  parameter int          C_START_DELAY        = 20,
  parameter logic [31:0] C_LFSR_POLY          = 32'h8020_0003
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_idle,
  output logic                              ap_done,
  input  logic [C_LENGTH_WIDTH-1:0]         cfg_length_bytes,
  input  logic [1:0]                        cfg_mode,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_seed,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_stride,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tid,
  output logic                              m_axis_tdest
);

  localparam int N     = C_NUMBER_BIT_WIDTH;
  localparam int L     = C_M_AXIS_TDATA_WIDTH / N;
  localparam int BYTES = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int LW    = C_LENGTH_WIDTH;
  localparam int BW    = LW - $clog2(BYTES) + 1;
  localparam int DCW   = $clog2(C_START_DELAY) + 1;

  gen_state_t       state;
  gen_state_t       state_n;
  logic             start_q;
  logic             launch;
  logic             hs;
  logic [DCW-1:0]   dly;
  logic [BW-1:0]    beats;
  logic [1:0]       mode_q;
  logic [N-1:0]     stride_q;
  logic [N-1:0]     incr;
  logic [BYTES-1:0] keep_q;
  logic [LW:0]      len_ext;
  logic [N-1:0]     lane_val [L];

  assign launch  = (state == ST_IDLE) && ap_start && !start_q;
  assign hs      = m_axis_tvalid && m_axis_tready;
  // one spare bit so the ceil() rounding cannot wrap at maximum length
  assign len_ext = {1'b0, cfg_length_bytes} + (LW+1)'(BYTES - 1);
  assign incr    = stride_q * N'(L);

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (launch)
          state_n = (cfg_length_bytes == '0) ? ST_DONE : ST_DELAY;
      end
      ST_DELAY: if (dly == '0) state_n = ST_RUN;
      ST_RUN:   if (hs && m_axis_tlast) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      start_q  <= 1'b0;
      dly      <= '0;
      beats    <= '0;
      mode_q   <= PM_INCR;
      stride_q <= '0;
      keep_q   <= '1;
    end else begin
      start_q <= ap_start;
      if (launch) begin
        dly      <= DCW'(C_START_DELAY - 1);
        beats    <= BW'(len_ext / (LW+1)'(BYTES));
        mode_q   <= cfg_mode;
        stride_q <= cfg_stride;
        keep_q   <= BYTES'(final_tkeep(64'(cfg_length_bytes), BYTES));
      end else begin
        if (state == ST_DELAY && dly != '0) dly <= dly - 1'b1;
        if (hs) beats <= beats - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < L; i++) begin : g_lane
    logic [N-1:0] base;
    logic [N-1:0] init;

    always_comb begin
      base = cfg_seed + N'(i);
      init = cfg_seed + N'(i) * cfg_stride;
      if (cfg_mode == PM_CONST)
        init = cfg_seed;
      else if (cfg_mode == PM_LFSR)
        init = (base == '0) ? N'(1) : base;
    end

    tinyyolo_pattern_lane #(
      .N    (N),
      .POLY (C_LFSR_POLY[N-1:0])
    ) u_lane (
      .aclk   (aclk),
      .areset (areset),
      .load   (launch),
      .init   (init),
      .step   (hs),
      .mode   (mode_q),
      .incr   (incr),
      .value  (lane_val[i])
    );

    assign m_axis_tdata[i*N +: N] = lane_val[i];
  end

  assign m_axis_tvalid = (state == ST_RUN);
  assign m_axis_tlast  = m_axis_tvalid && (beats == BW'(1));
  assign m_axis_tkeep  = m_axis_tlast ? keep_q : '1;
  assign m_axis_tstrb  = m_axis_tkeep;
  assign m_axis_tuser  = 1'b0;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;
  assign ap_idle       = (state == ST_IDLE);
  assign ap_done       = (state == ST_DONE);

endmodule

// File: tb/tb_tinyyolo_stream_pattern_gen.sv
// Self-checking bench for tinyyolo_stream_pattern_gen: vector table plus
// scoreboard of expected beats, and hand-written reset/restart sequences.
module tb_tinyyolo_stream_pattern_gen;

  localparam int D = 20;
  localparam int L = 4;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_idle, ap_done;
  logic [31:0]  cfg_length_bytes = '0;
  logic [1:0]   cfg_mode = '0;
  logic [31:0]  cfg_seed = '0;
  logic [31:0]  cfg_stride = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep, m_axis_tstrb;
  logic         m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest;

  always #5 aclk = ~aclk;

  tinyyolo_stream_pattern_gen #(
    .C_M_AXIS_TDATA_WIDTH (128),
    .C_NUMBER_BIT_WIDTH   (32),
    .C_LENGTH_WIDTH       (32),
    .C_START_DELAY        (D),
    .C_LFSR_POLY          (POLY)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .ap_start         (ap_start),
    .ap_idle          (ap_idle),
    .ap_done          (ap_done),
    .cfg_length_bytes (cfg_length_bytes),
    .cfg_mode         (cfg_mode),
    .cfg_seed         (cfg_seed),
    .cfg_stride       (cfg_stride),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tstrb     (m_axis_tstrb),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tid       (m_axis_tid),
    .m_axis_tdest     (m_axis_tdest)
  );

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    int          len;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [31:0] stride;
    int          pct;
    int          beats;
    logic [15:0] keep_last;
    bit          restart;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[8];
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input vec_t v);
    logic [31:0] lf [L];
    logic [31:0] val;
    beat_t x;
    for (int i = 0; i < L; i++) begin
      lf[i] = v.seed + 32'(i);
      if (lf[i] == 0) lf[i] = 32'd1;
    end
    for (int b = 0; b < v.beats; b++) begin
      x.data = '0;
      for (int i = 0; i < L; i++) begin
        case (v.mode)
          2'd1:    val = v.seed;
          2'd2:    val = lf[i];
          default: val = v.seed + 32'(b * L + i) * v.stride;
        endcase
        x.data[i*32 +: 32] = val;
      end
      x.last = (b == v.beats - 1);
      x.keep = x.last ? v.keep_last : 16'hffff;
      sb.push_back(x);
      for (int i = 0; i < L; i++)
        lf[i] = lf[i][0] ? ((lf[i] >> 1) ^ POLY) : (lf[i] >> 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int first = -1;
    int done_c = -1;
    int dones = 0;
    int last_hs = -1;
    int stop_at;
    bit stalled = 0;
    bit post_valid = 0;
    bit idle_bad = 0;
    logic [127:0] hd;
    logic [17:0]  hc;
    beat_t e;
    sb.delete();
    push_expected(v);
    stop_at = v.restart ? D + 4 : 3;
    @(negedge aclk);
    cfg_length_bytes = 32'(v.len);
    cfg_mode = v.mode;
    cfg_seed = v.seed;
    cfg_stride = v.stride;
    ap_start = 1'b1;
    m_axis_tready = 1'b0;
    @(posedge aclk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (c == 1 && v.restart) ap_start = 1'b0;
      if (c == 2 && !v.restart) ap_start = 1'b0;
      if (v.restart && c == D + 1) ap_start = 1'b1;
      if (v.restart && c == D + 2) begin
        cfg_seed = ~v.seed;
        cfg_stride = v.stride + 32'd5;
        cfg_mode = 2'd1;
        cfg_length_bytes = 32'd999;
      end
      m_axis_tready = ($urandom_range(99) < v.pct);
      if (stalled) begin
        check({tag, "/hold_data"}, 160'(m_axis_tdata), 160'(hd));
        check({tag, "/hold_ctl"},
              160'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep}), 160'(hc));
      end
      if (m_axis_tvalid && first < 0) first = c;
      if (done_c >= 0 && c > done_c) begin
        if (m_axis_tvalid) post_valid = 1;
        if (!ap_idle) idle_bad = 1;
      end
      if (ap_done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          check({tag, "/idle_in_done"}, 160'(ap_idle), 160'(0));
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata;
      hc = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep};
      if (m_axis_tvalid && m_axis_tready) begin
        last_hs = c;
        if (sb.size() == 0) begin
          check({tag, "/extra_beat"}, 160'(1), 160'(0));
        end else begin
          e = sb.pop_front();
          check({tag, "/data"}, 160'(m_axis_tdata), 160'(e.data));
          check({tag, "/keep_last"},
                160'({m_axis_tstrb, m_axis_tkeep, m_axis_tlast}),
                160'({e.keep, e.keep, e.last}));
        end
      end
      if (done_c >= 0 && c >= done_c + stop_at) break;
    end
    ap_start = 1'b0;
    m_axis_tready = 1'b0;
    check({tag, "/done_seen"}, 160'(done_c >= 0), 160'(1));
    check({tag, "/done_count"}, 160'(dones), 160'(1));
    check({tag, "/beats_left"}, 160'(sb.size()), 160'(0));
    check({tag, "/no_relaunch"}, 160'(post_valid), 160'(0));
    check({tag, "/idle_after"}, 160'(idle_bad), 160'(0));
    if (v.beats > 0) begin
      check({tag, "/latency"}, 160'(first), 160'(D));
      check({tag, "/done_timing"}, 160'(done_c - last_hs), 160'(1));
    end else begin
      check({tag, "/no_tvalid"}, 160'(first < 0), 160'(1));
      check({tag, "/done_at_k1"}, 160'(done_c), 160'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rst_ctl"},
          160'({m_axis_tvalid, m_axis_tlast, ap_done, ap_idle,
                m_axis_tuser, m_axis_tid, m_axis_tdest}),
          160'(7'b0001000));
    check({tag, "/rst_data"}, 160'({m_axis_tdata, m_axis_tkeep}),
          160'({128'd0, 16'hffff}));
  endtask

  initial begin
    int hs_n;
    int c;
    int dones;
    vec_t rv;
    vecs[0] = '{64, 2'd0, 32'd0, 32'd1, 100, 4, 16'hffff, 1'b0};
    vecs[1] = '{20, 2'd0, 32'd100, 32'd2, 100, 2, 16'h000f, 1'b0};
    vecs[2] = '{40, 2'd2, 32'd0, 32'd0, 50, 3, 16'h00ff, 1'b0};
    vecs[3] = '{16, 2'd1, 32'hdead_beef, 32'd0, 60, 1, 16'hffff, 1'b0};
    vecs[4] = '{33, 2'd3, 32'd5, 32'd3, 70, 3, 16'h0001, 1'b0};
    vecs[5] = '{0, 2'd0, 32'd9, 32'd9, 100, 0, 16'hffff, 1'b0};
    vecs[6] = '{64, 2'd0, 32'd1000, 32'd7, 100, 4, 16'hffff, 1'b1};
    vecs[7] = '{48, 2'd2, 32'h1234_5678, 32'd0, 100, 3, 16'hffff, 1'b0};

    repeat (3) @(negedge aclk);
    check_reset_outputs("por");
    areset = 1'b0;
    @(negedge aclk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort an 8-beat burst while beat 3 is on the bus
    @(negedge aclk);
    cfg_length_bytes = 32'd128;
    cfg_mode = 2'd0;
    cfg_seed = 32'd7;
    cfg_stride = 32'd1;
    ap_start = 1'b1;
    m_axis_tready = 1'b1;
    hs_n = 0;
    c = 0;
    while (hs_n < 2 && c < 200) begin
      @(negedge aclk);
      c++;
      if (c == 2) ap_start = 1'b0;
      if (m_axis_tvalid && m_axis_tready) hs_n++;
    end
    check("abort/reach_beat3", 160'(hs_n), 160'(2));
    @(negedge aclk);
    check("abort/beat3_lane0", 160'(m_axis_tdata[31:0]), 160'(32'd15));
    areset = 1'b1;
    @(negedge aclk);
    check_reset_outputs("abort");
    areset = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      if (ap_done || m_axis_tvalid) dones++;
    end
    check("abort/quiet", 160'(dones), 160'(0));
    rv = '{128, 2'd0, 32'd7, 32'd1, 80, 8, 16'hffff, 1'b0};
    run_vec(rv, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tinyyolo_stream_pattern_gen.md
# tinyyolo_stream_pattern_gen

Runtime-configurable AXI4-Stream test-pattern source for TinyYOLOHW kernel bring-up and loopback verification. It emits a programmable-length burst of incrementing, constant or pseudo-random lane data, with an exact final-beat tkeep. It is the parametrised successor of the fixed-length incrementing-number generator: length, seed, stride and mode are sampled at ap_start instead of fixed at elaboration. It sits between the kernel control block and the write-side AXI4-Stream FIFO/datamover.

## Interface
- C_M_AXIS_TDATA_WIDTH, 128, stream width in bits; must be a multiple of C_NUMBER_BIT_WIDTH and of 8.
- C_NUMBER_BIT_WIDTH, 32, lane width in bits; lanes L = TDATA_WIDTH/NUMBER_BIT_WIDTH.
- C_LENGTH_WIDTH, 32, width of the byte-length input.
- C_START_DELAY, 20, cycles from the start edge to the first tvalid; must be ≥1.
- C_LFSR_POLY, 32'h8020_0003, Galois feedback taps, low C_NUMBER_BIT_WIDTH bits used.
- aclk  in  1  clock.
- areset  in  1  reset; synchronous, active-high; clock aclk.
- ap_start  in  1  level; a rising edge launches a burst when idle.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse at burst end.
- cfg_length_bytes  in  C_LENGTH_WIDTH  burst length in bytes.
- cfg_mode  in  2  0=INCR, 1=CONST, 2=LFSR, 3=reserved (treated as INCR).
- cfg_seed  in  C_NUMBER_BIT_WIDTH  initial value.
- cfg_stride  in  C_NUMBER_BIT_WIDTH  INCR step per lane index.
- m_axis_tvalid/tready  out/in  1  stream handshake.
- m_axis_tdata  out  TDATA_WIDTH  lane i in bits [i*N +: N].
- m_axis_tkeep, m_axis_tstrb  out  TDATA_WIDTH/8  byte enables; tstrb equals tkeep.
- m_axis_tlast  out  1  final beat.
- m_axis_tuser, m_axis_tid, m_axis_tdest  out  1 each  tied to 0.

## Operation
- The FSM has four states: IDLE, DELAY, RUN, DONE.
- IDLE: the block samples ap_start each cycle. On ap_start=1 with the previous sample 0, it latches all cfg_* inputs and computes beats = ceil(len/BYTES), where BYTES = TDATA_WIDTH/8.
  - If len=0, the FSM goes to DONE and no beat is emitted.
  - Otherwise the FSM goes to DELAY.
- DELAY: a down-counter loaded with C_START_DELAY-1; the FSM goes to RUN when the counter reaches 0.
- RUN: tvalid=1. A beat is accepted when tvalid and tready are both high.
  - On acceptance, the beat counter decrements and the lanes advance.
  - Acceptance with tlast=1 moves the FSM to DONE.
- DONE: ap_done=1 for exactly one cycle, then the FSM returns to IDLE.
- Lane value for global element index e = b*L + i (beat b, lane i), all arithmetic mod 2^N:
  - INCR: seed + e*stride.
  - CONST: seed.
  - LFSR: lane i starts at seed+i, with 0 replaced by 1; each accepted beat applies one Galois step (shift right; XOR with POLY if the shifted-out bit is 1).
- tlast=1 exactly when the beat counter equals 1 in RUN.
- tkeep/tstrb on the tlast beat: low (len mod BYTES) bits set, or all ones if the remainder is 0. All other beats are all ones.
- Data bytes outside tkeep are not required to be zero.
- Start edges outside IDLE are ignored and not queued. A level held high across DONE→IDLE does not relaunch; a fresh 0→1 edge is required.
- cfg_* changes after the latch have no effect on the running burst.

## Timing
- Reset values: tvalid=0, tlast=0, ap_done=0, ap_idle=1, tdata=0, tkeep=all ones, state=IDLE, all counters=0.
- areset mid-burst: the cycle after reset asserts, all outputs are at reset values. The current beat is dropped and no ap_done is issued.
- Start latency: the start edge is sampled at clock k; the first tvalid=1 is at clock k+1+C_START_DELAY.
- While tvalid=1 and tready=0, tdata, tkeep and tlast are held stable; the AXI rule that tvalid is never withdrawn holds.
- Throughput is one beat per cycle under continuous tready.
- ap_done is registered: it is high in the cycle after the last handshake, and ap_idle returns to 1 one cycle later.
- For len=0: ap_done rises at k+1; no tvalid.
- Beat counter width is C_LENGTH_WIDTH-log2(BYTES)+1. A maximum length must not overflow.

## Structure
- Package tinyyolo_pattern_pkg holds:
  - the pattern_mode_t enum (INCR/CONST/LFSR);
  - the gen_state_t enum;
  - a function lfsr_step(value, poly);
  - a function final_tkeep(len, BYTES).
- Sub-module tinyyolo_pattern_lane, instantiated L times, holds one lane register.
  - Inputs: init, step enable, mode, L*stride increment.
  - Output: current value.
- The top level holds the FSM, the delay counter, the beat counter, and the tkeep/tlast logic.

## Test plan
- len=64, 128-bit bus, INCR, seed=0, stride=1, tready=1: 4 beats with lane values 0..15, tlast on beat 4, tkeep=FFFF, ap_done one cycle after the last handshake.
- len=20, INCR, seed=100, stride=2: 2 beats; beat 1 lanes 100,102,104,106; beat 2 lanes 108.. with tkeep=000F and tlast=1.
- LFSR, seed=0, random tready (50%): lane 0 starts at 1, the data sequence matches the model, tdata/tlast stay stable while stalled, ap_done count=1.
- len=0: ap_done pulses at k+1, tvalid never rises, ap_idle stays low for 1 cycle only.
- Second ap_start edge during RUN, and cfg change mid-burst: no effect, single burst with the original config.
- areset asserted at beat 3 of 8: tvalid=0 the next cycle, no ap_done; a new start edge then yields a full, correct 8-beat burst.
